// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: bundles the fetch stage's branch, instruction-memory and decode-side signals.
//   Branch side : BranchSignal, BranchAddress (into fetch)
//   Imem request: ImemReqValid, ImemReqAddr (out), ImemReqReady (in)
//   Imem resp   : ImemRespValid, ImemRespData (in)
//   Decode side : InstrValid, InstrData, InstrPC (out), InstrReady (in)
//   FetchPC     : next address to request (out)
// master = the fetch unit, slave = its environment.
interface fetch_pc_unit_if;
   logic        BranchSignal;
   logic [31:0] BranchAddress;
   logic        ImemReqValid;
   logic        ImemReqReady;
   logic [31:0] ImemReqAddr;
   logic        ImemRespValid;
   logic [31:0] ImemRespData;
   logic        InstrValid;
   logic        InstrReady;
   logic [31:0] InstrData;
   logic [31:0] InstrPC;
   logic [31:0] FetchPC;

   modport master (
      input  BranchSignal, BranchAddress, ImemReqReady, ImemRespValid, ImemRespData, InstrReady,
      output ImemReqValid, ImemReqAddr, InstrValid, InstrData, InstrPC, FetchPC
   );

   modport slave (
      output BranchSignal, BranchAddress, ImemReqReady, ImemRespValid, ImemRespData, InstrReady,
      input  ImemReqValid, ImemReqAddr, InstrValid, InstrData, InstrPC, FetchPC
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and instruction-fetch stage.
//   ClockInput : clock, all state on the rising edge
//   ResetInput : synchronous active-low reset
//   io_bus     : fetch_pc_unit_if.master (branch redirect, imem request/response, decode FIFO head)
// Keeps at most one memory request outstanding and buffers returned words with their PC in a
// FIFO_DEPTH-entry FIFO. A branch reloads FetchPC, flushes the FIFO and marks any in-flight
// response as stale so it is dropped on arrival.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned PC_INCREMENT = 4,
   parameter int unsigned FIFO_DEPTH   = 2
) (
   input logic             ClockInput,
   input logic             ResetInput,
   fetch_pc_unit_if.master io_bus
);
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam logic [31:0] PcInc = 32'(PC_INCREMENT);

   typedef enum logic [1:0] {StFetch, StWait, StDiscard} state_e;

   state_e          r_state;
   state_e          w_state_d;
   logic [31:0]     r_fetch_pc;
   logic [31:0]     r_req_pc;
   logic [31:0]     r_fifo_data [FIFO_DEPTH];
   logic [31:0]     r_fifo_pc   [FIFO_DEPTH];
   logic [PtrW-1:0] r_wptr;
   logic [PtrW-1:0] r_rptr;
   logic [CntW-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_req_valid;
   logic w_req_fire;
   logic w_push;
   logic w_pop;
   logic w_instr_valid;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CntW'(FIFO_DEPTH));

   // State register
   always_ff @(posedge ClockInput) begin
      if (!ResetInput) begin
         r_state <= StFetch;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic; a branch turns an outstanding request into a stale one
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StFetch: begin
            if (w_req_fire) w_state_d = StWait;
         end
         StWait: begin
            if (io_bus.BranchSignal) begin
               w_state_d = io_bus.ImemRespValid ? StFetch : StDiscard;
            end else if (io_bus.ImemRespValid) begin
               w_state_d = StFetch;
            end
         end
         StDiscard: begin
            if (io_bus.ImemRespValid) w_state_d = StFetch;
         end
         default: w_state_d = StFetch;
      endcase
   end

   // FSM outputs; a branch cycle masks request, push and pop
   always_comb begin
      w_req_valid   = (r_state == StFetch) && !w_full && !io_bus.BranchSignal && ResetInput;
      w_req_fire    = w_req_valid && io_bus.ImemReqReady;
      w_push        = (r_state == StWait) && io_bus.ImemRespValid && !io_bus.BranchSignal;
      w_instr_valid = !w_empty && !io_bus.BranchSignal;
      w_pop         = w_instr_valid && io_bus.InstrReady;
   end

   // PC and FIFO control
   always_ff @(posedge ClockInput) begin
      if (!ResetInput) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
      end else if (io_bus.BranchSignal) begin
         r_fetch_pc <= io_bus.BranchAddress;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
      end else begin
         if (w_req_fire) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + PcInc;
         end
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage needs no reset: the head is only exposed while count != 0
   always_ff @(posedge ClockInput) begin
      if (w_push) begin
         r_fifo_data[r_wptr] <= io_bus.ImemRespData;
         r_fifo_pc[r_wptr]   <= r_req_pc;
      end
   end

   assign io_bus.ImemReqValid = w_req_valid;
   assign io_bus.ImemReqAddr  = r_fetch_pc;
   assign io_bus.FetchPC      = r_fetch_pc;
   assign io_bus.InstrValid   = w_instr_valid;
   assign io_bus.InstrData    = w_empty ? 32'h0 : r_fifo_data[r_rptr];
   assign io_bus.InstrPC      = w_empty ? 32'h0 : r_fifo_pc[r_rptr];
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: randomized scoreboard bench for fetch_pc_unit.
// The reference model is the architectural fetch stream: instructions are expected in program
// order from the reset/branch target, each carrying the memory word at its PC; a branch or reset
// discards everything not yet delivered. A second instance checks RESET_PC wrap-around.
module tb_fetch_pc_unit;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_pc_unit_if bus ();
   fetch_pc_unit_if bus2 ();

   fetch_pc_unit #(.RESET_PC(32'h0000_0000), .PC_INCREMENT(4), .FIFO_DEPTH(2)) u_dut (
      .ClockInput (clk),
      .ResetInput (rst_n),
      .io_bus     (bus)
   );

   fetch_pc_unit #(.RESET_PC(32'hFFFF_FFF8), .PC_INCREMENT(4), .FIFO_DEPTH(2)) u_dut_wrap (
      .ClockInput (clk),
      .ResetInput (rst_n),
      .io_bus     (bus2)
   );

   int n_checks = 0;
   int n_errors = 0;
   int pop_count = 0;
   int wrap_pops = 0;

   exp_t        q[$];
   logic [31:0] model_pc = 32'h0;

   // bench memory: one outstanding request, random latency
   logic        mem_busy = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = 32'h0;

   int lat_min = 1, lat_max = 1, p_req_ready = 100, p_instr_ready = 100, p_branch = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC001_D00D;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: sample at mid-cycle, update model and memory, drive next inputs after the edge
   task automatic step();
      logic fire;
      @(negedge clk);
      #1;
      fire = bus.ImemReqValid && bus.ImemReqReady;
      if (bus.ImemRespValid) mem_busy = 1'b0;
      if (fire) begin
         mem_busy = 1'b1;
         mem_addr = bus.ImemReqAddr;
         mem_cnt  = int'($urandom_range(lat_max, lat_min));
      end
      if (!rst_n) begin
         q.delete();
         model_pc = 32'h0;
      end else if (bus.BranchSignal) begin
         q.delete();
         model_pc = bus.BranchAddress;
      end else if (fire) begin
         chk("req_addr", bus.ImemReqAddr, model_pc);
         q.push_back({model_pc, mem_word(model_pc)});
         model_pc = model_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      bus.ImemRespValid = 1'b0;
      bus.ImemRespData  = 32'h0;
      if (mem_busy) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            bus.ImemRespValid = 1'b1;
            bus.ImemRespData  = mem_word(mem_addr);
         end
      end
      bus.ImemReqReady = !mem_busy && ($urandom_range(99) < p_req_ready);
      bus.InstrReady   = ($urandom_range(99) < p_instr_ready);
      if (p_branch > 0) begin
         bus.BranchSignal  = ($urandom_range(99) < p_branch);
         bus.BranchAddress = $urandom() & 32'hFFFF_FFFC;
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) step();
      rst_n = 1'b1;
   endtask

   // Monitor: compares the FIFO head against the oldest expected instruction
   logic        prev_rst = 1'b1;
   logic        prev_branch = 1'b0;
   logic [31:0] prev_baddr = 32'h0;
   always @(negedge clk) begin
      n_checks++;
      assert (!(bus.ImemRespValid && !mem_busy)) else begin
         n_errors++;
         $display("FAIL resp_protocol: response with no request outstanding");
      end
      if (!rst_n) begin
         chk("rst_req_valid", 32'(bus.ImemReqValid), 32'h0);
      end else if (prev_rst) begin
         chk("rst_instr_valid", 32'(bus.InstrValid), 32'h0);
         chk("rst_instr_data", bus.InstrData, 32'h0);
         chk("rst_instr_pc", bus.InstrPC, 32'h0);
         chk("rst_fetch_pc", bus.FetchPC, 32'h0);
      end else if (prev_branch) begin
         chk("br_instr_valid", 32'(bus.InstrValid), 32'h0);
         chk("br_fetch_pc", bus.FetchPC, prev_baddr);
      end
      if (bus.InstrValid) begin
         if (q.size() == 0) begin
            chk("unexpected_instr_pc", bus.InstrPC, 32'hxxxx_xxxx);
         end else begin
            chk("instr_pc", bus.InstrPC, q[0].pc);
            chk("instr_data", bus.InstrData, q[0].data);
            if (bus.InstrReady) begin
               void'(q.pop_front());
               pop_count++;
            end
         end
      end
      prev_rst    = !rst_n;
      prev_branch = bus.BranchSignal && rst_n;
      prev_baddr  = bus.BranchAddress;
   end

   // Wrap instance: 1-cycle memory, always ready; stream starts at FFFF_FFF8
   logic        w_pend = 1'b0;
   logic [31:0] w_addr = 32'h0;
   logic [31:0] wrap_exp = 32'hFFFF_FFF8;
   always @(negedge clk) begin
      if (!rst_n) begin
         wrap_exp = 32'hFFFF_FFF8;
      end else if (bus2.InstrValid && bus2.InstrReady) begin
         chk("wrap_pc", bus2.InstrPC, wrap_exp);
         chk("wrap_data", bus2.InstrData, mem_word(wrap_exp));
         wrap_exp = wrap_exp + 32'd4;
         wrap_pops++;
      end
      w_pend = bus2.ImemReqValid && bus2.ImemReqReady;
      w_addr = bus2.ImemReqAddr;
   end
   always @(posedge clk) begin
      #1;
      bus2.ImemRespValid = w_pend;
      bus2.ImemRespData  = mem_word(w_addr);
   end

   initial begin
      int base;
      bus.BranchSignal = 1'b0;  bus.BranchAddress = 32'h0;
      bus.ImemReqReady = 1'b0;  bus.ImemRespValid = 1'b0;  bus.ImemRespData = 32'h0;
      bus.InstrReady   = 1'b0;
      bus2.BranchSignal = 1'b0; bus2.BranchAddress = 32'h0; bus2.ImemReqReady = 1'b1;
      bus2.InstrReady   = 1'b1; bus2.ImemRespValid = 1'b0;  bus2.ImemRespData = 32'h0;

      // Throughput: 1-cycle memory, decode always ready -> one instruction per two cycles
      do_reset(3);
      repeat (6) step();
      base = pop_count;
      repeat (20) step();
      chk("throughput_pops", 32'(pop_count - base), 32'd10);

      // Back-pressure: FIFO fills with PC 0 and 4, then requests stop
      do_reset(2);
      p_instr_ready = 0;
      bus.InstrReady = 1'b0;
      repeat (10) step();
      #1;
      chk("full_req_valid", 32'(bus.ImemReqValid), 32'h0);
      chk("full_instr_valid", 32'(bus.InstrValid), 32'h1);
      chk("full_head_pc", bus.InstrPC, 32'h0);
      chk("full_fetch_pc", bus.FetchPC, 32'h8);
      p_instr_ready = 100;
      repeat (12) step();

      // Branch while waiting on a slow response: stale word dropped, refetch at 0x100
      do_reset(2);
      lat_min = 4; lat_max = 4;
      step();
      bus.BranchSignal = 1'b1; bus.BranchAddress = 32'h100;
      step();
      bus.BranchSignal = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("discard_req_valid", 32'(bus.ImemReqValid), 32'h0);
         chk("discard_instr_valid", 32'(bus.InstrValid), 32'h0);
         chk("discard_fetch_pc", bus.FetchPC, 32'h100);
         step();
      end
      #1;
      chk("redirect_req_valid", 32'(bus.ImemReqValid), 32'h1);
      chk("redirect_req_addr", bus.ImemReqAddr, 32'h100);
      lat_min = 1; lat_max = 1;
      repeat (8) step();

      // Branch coincident with a response while decode is ready and the FIFO holds an entry
      do_reset(2);
      p_instr_ready = 0;
      step();
      step();
      lat_min = 2; lat_max = 2;
      step();
      step();
      #1;
      chk("coinc_resp_valid", 32'(bus.ImemRespValid), 32'h1);
      bus.BranchSignal = 1'b1; bus.BranchAddress = 32'h2000; bus.InstrReady = 1'b1;
      p_instr_ready = 100;
      step();
      bus.BranchSignal = 1'b0;
      #1;
      chk("coinc_instr_valid", 32'(bus.InstrValid), 32'h0);
      chk("coinc_req_valid", 32'(bus.ImemReqValid), 32'h1);
      chk("coinc_req_addr", bus.ImemReqAddr, 32'h2000);
      lat_min = 1; lat_max = 1;
      repeat (8) step();

      // Reset while waiting with a FIFO entry; the late stale response must be ignored
      do_reset(2);
      p_instr_ready = 0;
      step();
      step();
      lat_min = 4; lat_max = 4;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("midrst_instr_valid", 32'(bus.InstrValid), 32'h0);
      chk("midrst_fetch_pc", bus.FetchPC, 32'h0);
      chk("midrst_req_valid", 32'(bus.ImemReqValid), 32'h1);
      p_instr_ready = 100; lat_min = 1; lat_max = 1;
      repeat (12) step();

      // Random traffic: random latency, ready, branches, occasional reset
      lat_min = 1; lat_max = 4; p_req_ready = 70; p_instr_ready = 60; p_branch = 8;
      for (int i = 0; i < 3000; i++) begin
         if (i % 700 == 699) do_reset(2);
         step();
      end
      p_branch = 0;
      bus.BranchSignal = 1'b0;
      repeat (10) step();

      chk("pops_seen", 32'(pop_count > 300), 32'h1);
      chk("wrap_pops_seen", 32'(wrap_pops >= 3), 32'h1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
